// File: rtl/audio_peak_meter_if.sv
// Sample-stream and meter-output bundle for audio_peak_meter.
// The master side feeds PCM samples and clear; the slave side is the meter.
interface audio_peak_meter_if;
    logic [15:0] smpl;      // signed two's-complement PCM
    logic        smpl_vld;
    logic        clr_pk;
    logic [14:0] mag;
    logic        mag_vld;
    logic [14:0] peak;
    logic [17:0] lvl_bar;
    logic        clip;

    modport master (
        output smpl, smpl_vld, clr_pk,
        input  mag, mag_vld, peak, lvl_bar, clip
    );

    modport slave (
        input  smpl, smpl_vld, clr_pk,
        output mag, mag_vld, peak, lvl_bar, clip
    );
endinterface

// File: rtl/audio_peak_meter.sv
// Streaming peak meter: |sample| -> held/decaying peak -> 18-LED thermometer bar.
// Define AUDIO_PEAK_CLIP_EN to build the sticky clip detector; otherwise clip is tied low.
module audio_peak_meter #(
    parameter int HOLD_SMPLS = 1024,
    parameter int DECAY_SHFT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    audio_peak_meter_if.slave bus
);

    localparam int               HCW         = $clog2(HOLD_SMPLS) + 1;
    localparam logic [HCW-1:0]   HOLD_RELOAD = HCW'(HOLD_SMPLS - 1);
    localparam int               BAR_STEP    = 1820;

    typedef enum logic {
        ST_HOLD,
        ST_DECAY
    } state_t;

    logic [14:0]    mag_q;
    logic           mag_vld_q;
    logic [15:0]    smpl_neg;
    logic [14:0]    smpl_mag;

    state_t         state, state_nxt;
    logic [14:0]    peak_q, peak_nxt;
    logic [HCW-1:0] hold_cnt, hold_nxt;
    logic [14:0]    dec_step, peak_dec;
    logic [17:0]    bar_q, bar_nxt;

    // Magnitude: -32768 has no positive 15-bit counterpart and saturates.
    assign smpl_neg = ~bus.smpl + 16'd1;

    always_comb begin
        if (!bus.smpl[15])
            smpl_mag = bus.smpl[14:0];
        else if (bus.smpl == 16'h8000)
            smpl_mag = 15'h7FFF;
        else
            smpl_mag = smpl_neg[14:0];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q     <= '0;
            mag_vld_q <= 1'b0;
        end else begin
            mag_vld_q <= bus.smpl_vld;
            if (bus.smpl_vld)
                mag_q <= smpl_mag;
        end
    end

    // Decay step is a fraction of the peak but never less than one LSB.
    assign dec_step = ((peak_q >> DECAY_SHFT) == 15'd0) ? 15'd1 : (peak_q >> DECAY_SHFT);
    assign peak_dec = (peak_q == 15'd0) ? 15'd0 : peak_q - dec_step;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        peak_nxt  = peak_q;
        hold_nxt  = hold_cnt;
        if (bus.clr_pk) begin
            state_nxt = ST_DECAY;
            peak_nxt  = '0;
            hold_nxt  = '0;
        end else if (mag_vld_q) begin
            unique case (state)
                ST_HOLD: begin
                    if (mag_q >= peak_q) begin
                        peak_nxt = mag_q;
                        hold_nxt = HOLD_RELOAD;
                    end else if (hold_cnt == '0) begin
                        state_nxt = ST_DECAY;
                    end else begin
                        hold_nxt = hold_cnt - HCW'(1);
                    end
                end
                ST_DECAY: begin
                    if (mag_q >= peak_dec) begin
                        peak_nxt  = mag_q;
                        hold_nxt  = HOLD_RELOAD;
                        state_nxt = ST_HOLD;
                    end else begin
                        peak_nxt = peak_dec;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_DECAY;
            peak_q   <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            peak_q   <= peak_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Bar segment i lights once the peak reaches (i+1) steps of 1820.
    always_comb begin
        bar_nxt = '0;
        for (int i = 0; i < 18; i++)
            bar_nxt[i] = (32'(peak_q) >= 32'((i + 1) * BAR_STEP));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bar_q <= '0;
        else
            bar_q <= bar_nxt;
    end

`ifdef AUDIO_PEAK_CLIP_EN
    logic clip_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            clip_q <= 1'b0;
        else if (bus.clr_pk)
            clip_q <= 1'b0;
        else if (bus.smpl_vld && (bus.smpl == 16'h7FFF || bus.smpl == 16'h8000))
            clip_q <= 1'b1;
    end

    assign bus.clip = clip_q;
`else
    assign bus.clip = 1'b0;
`endif

    assign bus.mag     = mag_q;
    assign bus.mag_vld = mag_vld_q;
    assign bus.peak    = peak_q;
    assign bus.lvl_bar = bar_q;

endmodule

// File: tb/tb_audio_peak_meter.sv
// Scoreboard bench for audio_peak_meter (HOLD_SMPLS=4, DECAY_SHFT=4).
// Clip expectations follow AUDIO_PEAK_CLIP_EN as compiled.
module tb_audio_peak_meter;

    localparam int HOLD_SMPLS = 4;
    localparam int DECAY_SHFT = 4;
`ifdef AUDIO_PEAK_CLIP_EN
    localparam logic CLIP_EXP = 1'b1;
`else
    localparam logic CLIP_EXP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    audio_peak_meter_if bus ();

    audio_peak_meter #(
        .HOLD_SMPLS(HOLD_SMPLS),
        .DECAY_SHFT(DECAY_SHFT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [14:0] mag_q[$];
    logic [14:0] peak_q[$];
    logic        pk_due = 1'b0;

    function automatic logic [14:0] exp_mag(input logic [15:0] s);
        int v;
        v = int'($signed(s));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return 15'(v);
    endfunction

    // Monitor: mag checked when mag_vld shows, that sample's peak one cycle later.
    always @(negedge clk) begin
        logic [14:0] e;
        if (!rst_n) begin
            mag_q.delete();
            peak_q.delete();
            pk_due = 1'b0;
        end else begin
            if (pk_due) begin
                checks++;
                if (peak_q.size() == 0) begin
                    errors++;
                    $display("FAIL peak_sb: unexpected update, got %0d", bus.peak);
                end else begin
                    e = peak_q.pop_front();
                    if (bus.peak !== e) begin
                        errors++;
                        $display("FAIL peak_sb: got %0d, expected %0d", bus.peak, e);
                    end
                end
            end
            pk_due = 1'b0;
            if (bus.mag_vld === 1'b1) begin
                checks++;
                if (mag_q.size() == 0) begin
                    errors++;
                    $display("FAIL mag_sb: unexpected mag_vld, got %0d", bus.mag);
                end else begin
                    e = mag_q.pop_front();
                    if (bus.mag !== e) begin
                        errors++;
                        $display("FAIL mag_sb: got %0d, expected %0d", bus.mag, e);
                    end
                end
                pk_due = 1'b1;
            end
        end
    end

    // Called at posedge+1; inputs are held across the next edge and released at posedge+1.
    task automatic drive(input logic [15:0] s, input logic v, input logic c,
                         input logic [14:0] exp_pk);
        bus.smpl     = s;
        bus.smpl_vld = v;
        bus.clr_pk   = c;
        if (v) begin
            mag_q.push_back(exp_mag(s));
            peak_q.push_back(exp_pk);
        end
        @(posedge clk);
        #1;
        bus.smpl_vld = 1'b0;
        bus.clr_pk   = 1'b0;
    endtask

    task automatic clear();
        drive(16'd0, 1'b0, 1'b1, 15'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        repeat (2) @(posedge clk);
        while ((mag_q.size() != 0 || peak_q.size() != 0 || pk_due) && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (mag_q.size() != 0 || peak_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d mag and %0d peak results still pending, expected 0",
                     mag_q.size(), peak_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.mag !== 15'd0 || bus.mag_vld !== 1'b0 || bus.peak !== 15'd0 ||
            bus.lvl_bar !== 18'd0 || bus.clip !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: mag=%0d vld=%b peak=%0d bar=%h clip=%b, expected all 0",
                     bus.mag, bus.mag_vld, bus.peak, bus.lvl_bar, bus.clip);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(16'd30000, 1'b1, 1'b0, 15'd30000);
        drive(16'd30000, 1'b1, 1'b0, 15'd30000);
        checks++;
        if (bus.peak !== 15'd30000) begin
            errors++;
            $display("FAIL pre_reset_peak: got %0d, expected 30000", bus.peak);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mag !== 15'd0 || bus.mag_vld !== 1'b0 || bus.peak !== 15'd0 ||
            bus.lvl_bar !== 18'd0 || bus.clip !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: mag=%0d vld=%b peak=%0d bar=%h clip=%b, expected all 0",
                     bus.mag, bus.mag_vld, bus.peak, bus.lvl_bar, bus.clip);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_magnitude();
        drive(16'hFC18, 1'b1, 1'b0, 15'd1000);
        checks++;
        if (bus.mag_vld !== 1'b1 || bus.mag !== 15'd1000) begin
            errors++;
            $display("FAIL mag_latency: vld=%b mag=%0d, expected vld=1 mag=1000",
                     bus.mag_vld, bus.mag);
        end
        drive(16'h8000, 1'b1, 1'b0, 15'd32767);
        drive(16'd12345, 1'b1, 1'b0, 15'd32767);
        drain();
        checks++;
        if (bus.clip !== CLIP_EXP) begin
            errors++;
            $display("FAIL clip_neg_full: got %b, expected %b", bus.clip, CLIP_EXP);
        end
        clear();
        checks++;
        if (bus.peak !== 15'd0 || bus.clip !== 1'b0) begin
            errors++;
            $display("FAIL clr_pk: peak=%0d clip=%b, expected 0 0", bus.peak, bus.clip);
        end
    endtask

    task automatic test_hold();
        logic [15:0] s[7] = '{16'd16000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        logic [14:0] p[7] = '{15'd16000, 15'd16000, 15'd16000, 15'd16000, 15'd16000,
                              15'd15000, 15'd14063};
        for (int i = 0; i < 7; i++)
            drive(s[i], 1'b1, 1'b0, p[i]);
        drain();
        checks++;
        if (bus.lvl_bar !== 18'h0007F) begin
            errors++;
            $display("FAIL bar_14063: got %h, expected 0007f", bus.lvl_bar);
        end
        repeat (50) @(posedge clk);
        #1;
        checks++;
        if (bus.peak !== 15'd14063) begin
            errors++;
            $display("FAIL vld_gap: got %0d, expected 14063", bus.peak);
        end
        drive(16'd0, 1'b1, 1'b0, 15'd13185);
        drain();
    endtask

    task automatic test_tie_retrigger();
        logic [15:0] s[15] = '{16'd16000, 16'd0, 16'd0, 16'd16000, 16'd0, 16'd0, 16'd0, 16'd0,
                               16'd0, 16'd20000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        logic [14:0] p[15] = '{15'd16000, 15'd16000, 15'd16000, 15'd16000, 15'd16000,
                               15'd16000, 15'd16000, 15'd16000, 15'd15000, 15'd20000,
                               15'd20000, 15'd20000, 15'd20000, 15'd20000, 15'd18750};
        clear();
        for (int i = 0; i < 15; i++)
            drive(s[i], 1'b1, 1'b0, p[i]);
        drain();
    endtask

    task automatic test_floor();
        logic [14:0] p[10] = '{15'd3, 15'd3, 15'd3, 15'd3, 15'd3, 15'd2, 15'd1, 15'd0,
                               15'd0, 15'd0};
        clear();
        drive(16'd3, 1'b1, 1'b0, p[0]);
        for (int i = 1; i < 10; i++)
            drive(16'd0, 1'b1, 1'b0, p[i]);
        drain();
    endtask

    task automatic test_bargraph();
        clear();
        drive(16'd32767, 1'b1, 1'b0, 15'd32767);
        drain();
        checks++;
        if (bus.lvl_bar !== 18'h3FFFF) begin
            errors++;
            $display("FAIL bar_full: got %h, expected 3ffff", bus.lvl_bar);
        end
        clear();
        drive(16'd1819, 1'b1, 1'b0, 15'd1819);
        drain();
        checks++;
        if (bus.lvl_bar !== 18'h00000) begin
            errors++;
            $display("FAIL bar_1819: got %h, expected 00000", bus.lvl_bar);
        end
        drive(16'd1820, 1'b1, 1'b0, 15'd1820);
        drain();
        checks++;
        if (bus.lvl_bar !== 18'h00001) begin
            errors++;
            $display("FAIL bar_1820: got %h, expected 00001", bus.lvl_bar);
        end
        clear();
        drive(16'd32759, 1'b1, 1'b0, 15'd32759);
        drain();
        checks++;
        if (bus.lvl_bar !== 18'h1FFFF) begin
            errors++;
            $display("FAIL bar_32759: got %h, expected 1ffff", bus.lvl_bar);
        end
    endtask

    task automatic test_clr_coincident();
        drive(16'd30000, 1'b1, 1'b0, 15'd0);
        clear();
        checks++;
        if (bus.peak !== 15'd0) begin
            errors++;
            $display("FAIL clr_coincident: got %0d, expected 0", bus.peak);
        end
        drain();
        checks++;
        if (bus.lvl_bar !== 18'd0) begin
            errors++;
            $display("FAIL bar_after_clr: got %h, expected 00000", bus.lvl_bar);
        end
        drive(16'd500, 1'b1, 1'b0, 15'd500);
        drain();
    endtask

    task automatic test_clip();
        clear();
        checks++;
        if (bus.clip !== 1'b0) begin
            errors++;
            $display("FAIL clip_cleared: got %b, expected 0", bus.clip);
        end
        drive(16'h7FFF, 1'b1, 1'b0, 15'd32767);
        checks++;
        if (bus.clip !== CLIP_EXP) begin
            errors++;
            $display("FAIL clip_set: got %b, expected %b", bus.clip, CLIP_EXP);
        end
        drive(16'd100, 1'b1, 1'b0, 15'd32767);
        drive(16'hFF00, 1'b1, 1'b0, 15'd32767);
        drain();
        checks++;
        if (bus.clip !== CLIP_EXP) begin
            errors++;
            $display("FAIL clip_sticky: got %b, expected %b", bus.clip, CLIP_EXP);
        end
        clear();
        checks++;
        if (bus.clip !== 1'b0) begin
            errors++;
            $display("FAIL clip_clr: got %b, expected 0", bus.clip);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.smpl     = 16'd0;
        bus.smpl_vld = 1'b0;
        bus.clr_pk   = 1'b0;
        test_reset();
        test_magnitude();
        test_hold();
        test_tie_retrigger();
        test_floor();
        test_bargraph();
        test_clr_coincident();
        test_clip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
